// File: rtl/fpu_pkg.sv
// Shared definitions for the long-latency FPU issue path.
package fpu_pkg;

    // funct5 encodings for the multi-cycle op class
    localparam logic [4:0]  FDIV      = 5'b00011;
    localparam logic [4:0]  FSQRT     = 5'b01011;

    // Result returned when the watchdog gives up on the core
    localparam logic [31:0] CANON_NAN = 32'h7fc00000;

    // Issue-queue sequencer states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        RESP  = 2'd2,
        DRAIN = 2'd3
    } lq_state_t;

endpackage

// File: rtl/fpu_req_fifo.sv
// Generic synchronous FIFO with wrap-bit pointers and a synchronous clear.
module fpu_req_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             do_push;
    logic             do_pop;

    // Same index with differing wrap bits means every slot is occupied
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign dout    = mem[rd_ptr[AW-1:0]];
    assign do_push = push && !full && !clear;
    assign do_pop  = pop && !empty && !clear;

    // Pointer update; clear wins over any same-cycle push/pop
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    // Storage write; contents are don't-care until the pointers cover them
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/fpu_long_issue_queue.sv
// Front end for the multi-cycle FPU core: buffers tagged requests, issues one
// at a time, returns tagged results, with watchdog and flush/drain handling.
module fpu_long_issue_queue
    import fpu_pkg::*;
#(
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned TAG_W   = 5,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [31:0]      req_x,
    input  logic [31:0]      req_y,
    input  logic [31:0]      req_z,
    input  logic [4:0]       req_funct5,
    input  logic [2:0]       req_rm,
    input  logic [TAG_W-1:0] req_tag,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [31:0]      resp_res,
    output logic [TAG_W-1:0] resp_tag,
    output logic             resp_timeout,
    output logic             busy,
    output logic             err,
    output logic             core_en,
    output logic [31:0]      core_x,
    output logic [31:0]      core_y,
    output logic [31:0]      core_z,
    output logic [4:0]       core_funct5,
    output logic [2:0]       core_rm,
    input  logic             core_valid,
    input  logic [31:0]      core_res
);

    localparam int unsigned PW       = 3*32 + 5 + 3 + TAG_W;
    localparam int unsigned CW       = $clog2(TIMEOUT);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    lq_state_t        state;
    lq_state_t        state_nxt;

    logic [PW-1:0]    fifo_din;
    logic [PW-1:0]    fifo_dout;
    logic             fifo_full;
    logic             fifo_empty;
    logic             fifo_push;
    logic             fifo_pop;

    logic [31:0]      head_x;
    logic [31:0]      head_y;
    logic [31:0]      head_z;
    logic [4:0]       head_funct5;
    logic [2:0]       head_rm;
    logic [TAG_W-1:0] head_tag;

    logic [31:0]      op_x;
    logic [31:0]      op_y;
    logic [31:0]      op_z;
    logic [4:0]       op_funct5;
    logic [2:0]       op_rm;
    logic [TAG_W-1:0] op_tag;

    logic [31:0]      res_q;
    logic [TAG_W-1:0] tag_q;
    logic             to_q;
    logic             err_q;
    logic             en_q;
    logic             rdy_en;
    logic [CW-1:0]    wd_cnt;
    logic             wd_expire;
    logic             core_done;

    // rdy_en keeps req_ready low while in reset and for the release cycle
    assign req_ready = rdy_en && !fifo_full && !flush;
    assign fifo_push = req_valid && req_ready;
    assign fifo_din  = {req_x, req_y, req_z, req_funct5, req_rm, req_tag};
    assign {head_x, head_y, head_z, head_funct5, head_rm, head_tag} = fifo_dout;

    fpu_req_fifo #(
        .WIDTH (PW),
        .DEPTH (DEPTH)
    ) u_req_fifo (
        .clk   (clk),
        .rst   (rst),
        .clear (flush),
        .push  (fifo_push),
        .din   (fifo_din),
        .pop   (fifo_pop),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign wd_expire = (wd_cnt == CNT_LAST);
    assign core_done = core_valid || wd_expire;

    assign core_en      = en_q;
    assign core_x       = op_x;
    assign core_y       = op_y;
    assign core_z       = op_z;
    assign core_funct5  = op_funct5;
    assign core_rm      = op_rm;
    assign resp_valid   = (state == RESP);
    assign resp_res     = res_q;
    assign resp_tag     = tag_q;
    assign resp_timeout = to_q;
    assign err          = err_q;
    assign busy         = (state != IDLE) || !fifo_empty;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state and FIFO pop decision
    always_comb begin
        state_nxt = state;
        fifo_pop  = 1'b0;
        case (state)
            IDLE: begin
                if (!flush && !fifo_empty) begin
                    fifo_pop  = 1'b1;
                    state_nxt = WAIT;
                end
            end
            WAIT: begin
                // A flush that coincides with completion has nothing left to drain
                if (flush)          state_nxt = core_done ? IDLE : DRAIN;
                else if (core_done) state_nxt = RESP;
            end
            RESP: begin
                if (flush || resp_ready) state_nxt = IDLE;
            end
            DRAIN: begin
                if (core_done) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Operand capture, start pulse, watchdog counter and response registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_x      <= '0;
            op_y      <= '0;
            op_z      <= '0;
            op_funct5 <= '0;
            op_rm     <= '0;
            op_tag    <= '0;
            en_q      <= 1'b0;
            wd_cnt    <= '0;
            res_q     <= '0;
            tag_q     <= '0;
            to_q      <= 1'b0;
            err_q     <= 1'b0;
            rdy_en    <= 1'b0;
        end else begin
            rdy_en <= 1'b1;
            en_q   <= fifo_pop;
            if (fifo_pop) begin
                op_x      <= head_x;
                op_y      <= head_y;
                op_z      <= head_z;
                op_funct5 <= head_funct5;
                op_rm     <= head_rm;
                op_tag    <= head_tag;
                wd_cnt    <= '0;
            end else if ((state == WAIT || state == DRAIN) && !wd_expire) begin
                wd_cnt <= wd_cnt + CW'(1);
            end
            if (state == WAIT && !flush) begin
                if (core_valid) begin
                    res_q <= core_res;
                    tag_q <= op_tag;
                    to_q  <= 1'b0;
                end else if (wd_expire) begin
                    res_q <= CANON_NAN;
                    tag_q <= op_tag;
                    to_q  <= 1'b1;
                end
            end
            if (core_valid && (state == IDLE || state == RESP)) err_q <= 1'b1;
        end
    end

endmodule

// File: tb/tb_fpu_long_issue_queue.sv
// Randomized and directed bench for fpu_long_issue_queue with a stub core and
// a queue-based scoreboard of accepted, issued and returned operations.
module tb_fpu_long_issue_queue;
    import fpu_pkg::*;

    localparam int DEPTH   = 4;
    localparam int TAG_W   = 5;
    localparam int TIMEOUT = 64;

    logic             clk = 1'b0;
    logic             rst;
    logic             flush;
    logic             req_valid;
    logic             req_ready;
    logic [31:0]      req_x;
    logic [31:0]      req_y;
    logic [31:0]      req_z;
    logic [4:0]       req_funct5;
    logic [2:0]       req_rm;
    logic [TAG_W-1:0] req_tag;
    logic             resp_valid;
    logic             resp_ready;
    logic [31:0]      resp_res;
    logic [TAG_W-1:0] resp_tag;
    logic             resp_timeout;
    logic             busy;
    logic             err;
    logic             core_en;
    logic [31:0]      core_x;
    logic [31:0]      core_y;
    logic [31:0]      core_z;
    logic [4:0]       core_funct5;
    logic [2:0]       core_rm;
    logic             core_valid;
    logic [31:0]      core_res;

    fpu_long_issue_queue #(
        .DEPTH   (DEPTH),
        .TAG_W   (TAG_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .flush        (flush),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_x        (req_x),
        .req_y        (req_y),
        .req_z        (req_z),
        .req_funct5   (req_funct5),
        .req_rm       (req_rm),
        .req_tag      (req_tag),
        .resp_valid   (resp_valid),
        .resp_ready   (resp_ready),
        .resp_res     (resp_res),
        .resp_tag     (resp_tag),
        .resp_timeout (resp_timeout),
        .busy         (busy),
        .err          (err),
        .core_en      (core_en),
        .core_x       (core_x),
        .core_y       (core_y),
        .core_z       (core_z),
        .core_funct5  (core_funct5),
        .core_rm      (core_rm),
        .core_valid   (core_valid),
        .core_res     (core_res)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0]      x;
        logic [31:0]      y;
        logic [31:0]      z;
        logic [4:0]       f5;
        logic [2:0]       rm;
        logic [TAG_W-1:0] tag;
        bit               hang;
    } op_t;

    op_t pend_q[$];
    op_t infl_q[$];

    int n_tests = 0;
    int n_fail  = 0;

    int lat_cfg       = 5;
    bit hang_cfg      = 1'b0;
    bit rand_lat      = 1'b0;
    bit stray_req     = 1'b0;
    int st_pend       = 0;
    bit ready_ok      = 1'b0;
    bit last_acc      = 1'b0;
    bit prev_rv       = 1'b0;
    bit saw_not_ready = 1'b0;
    int acc_cyc       = 0;
    int en_cyc        = 0;
    int rv_cyc        = 0;
    int en_count      = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Stub core result: any fixed mix of the operands it holds at completion
    function automatic logic [31:0] stub_res(input logic [31:0] x, input logic [31:0] y,
                                             input logic [31:0] z, input logic [4:0] f5,
                                             input logic [2:0] rm);
        return (x + {y[15:0], y[31:16]}) ^ z ^ {rm, 24'h0, f5};
    endfunction

    // Scoreboard, ready model and stub core, all evaluated mid-cycle
    always @(negedge clk) begin
        op_t o;
        int  nlat;
        bit  nhang;
        bit  fire;
        if (rst) begin
            pend_q.delete();
            infl_q.delete();
            st_pend    = 0;
            core_valid = 1'b0;
            prev_rv    = 1'b0;
            last_acc   = 1'b0;
        end else begin
            fire  = 1'b0;
            nlat  = 0;
            nhang = 1'b0;
            if (core_en) begin
                en_count++;
                en_cyc = cyc;
                fire   = 1'b1;
                check_eq("one_outstanding", infl_q.size(), 0);
                if (pend_q.size() == 0) begin
                    check_eq("spurious_en", core_en, 1'b0);
                end else begin
                    o = pend_q.pop_front();
                    check_eq("core_x", core_x, o.x);
                    check_eq("core_y", core_y, o.y);
                    check_eq("core_z", core_z, o.z);
                    check_eq("core_funct5", core_funct5, o.f5);
                    check_eq("core_rm", core_rm, o.rm);
                    nhang  = hang_cfg || (rand_lat && $urandom_range(0, 9) == 0);
                    nlat   = rand_lat ? int'($urandom_range(1, 8)) : lat_cfg;
                    o.hang = nhang;
                    infl_q.push_back(o);
                end
            end
            check_eq("req_ready", req_ready, ready_ok && (pend_q.size() < DEPTH) && !flush);
            if (req_valid && !req_ready) saw_not_ready = 1'b1;
            if (resp_valid && !prev_rv) rv_cyc = cyc;
            prev_rv = resp_valid;
            if (resp_valid && resp_ready && !flush) begin
                if (infl_q.size() == 0) begin
                    check_eq("spurious_resp", resp_valid, 1'b0);
                end else begin
                    o = infl_q.pop_front();
                    check_eq("resp_tag", resp_tag, o.tag);
                    check_eq("resp_res", resp_res, o.hang ? CANON_NAN : stub_res(o.x, o.y, o.z, o.f5, o.rm));
                    check_eq("resp_timeout", resp_timeout, o.hang);
                end
            end
            last_acc = req_valid && req_ready;
            if (last_acc) begin
                o.x = req_x; o.y = req_y; o.z = req_z;
                o.f5 = req_funct5; o.rm = req_rm; o.tag = req_tag; o.hang = 1'b0;
                pend_q.push_back(o);
                acc_cyc = cyc;
            end
            if (flush) begin
                pend_q.delete();
                infl_q.delete();
            end
            core_valid = 1'b0;
            if (st_pend > 0) begin
                st_pend--;
                if (st_pend == 0) begin
                    core_valid = 1'b1;
                    core_res   = stub_res(core_x, core_y, core_z, core_funct5, core_rm);
                end
            end
            if (fire && !nhang) st_pend = nlat;
            if (stray_req) begin
                core_valid = 1'b1;
                core_res   = 32'h1234_5678;
                stray_req  = 1'b0;
            end
            ready_ok = 1'b1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [TAG_W-1:0] tag, input logic [31:0] x, input logic [31:0] y,
                        input logic [31:0] z, input logic [4:0] f5, input int budget);
        req_valid  = 1'b1;
        req_x      = x;
        req_y      = y;
        req_z      = z;
        req_funct5 = f5;
        req_rm     = 3'($urandom_range(0, 7));
        req_tag    = tag;
        for (int i = 0; i < budget; i++) begin
            #1;
            if (req_ready) begin
                tick();
                req_valid = 1'b0;
                return;
            end
            tick();
        end
        check_eq("send_accept", req_ready, 1'b1);
        req_valid = 1'b0;
    endtask

    task automatic send_rand(input logic [TAG_W-1:0] tag);
        send(tag, $urandom, $urandom, $urandom, FSQRT, 20);
    endtask

    task automatic wait_idle(input string tag, input int budget);
        for (int i = 0; i < budget; i++) begin
            if (!busy && pend_q.size() == 0 && infl_q.size() == 0 && st_pend == 0) break;
            tick();
        end
        check_eq(tag, busy, 1'b0);
    endtask

    task automatic wait_resp(input string tag, input int budget);
        for (int i = 0; i < budget; i++) begin
            if (resp_valid) break;
            tick();
        end
        check_eq(tag, resp_valid, 1'b1);
    endtask

    task automatic check_outputs_zero(input string tag);
        check_eq({tag, "_req_ready"}, req_ready, 1'b0);
        check_eq({tag, "_resp_valid"}, resp_valid, 1'b0);
        check_eq({tag, "_resp_res"}, resp_res, 32'h0);
        check_eq({tag, "_resp_timeout"}, resp_timeout, 1'b0);
        check_eq({tag, "_core_en"}, core_en, 1'b0);
        check_eq({tag, "_core_x"}, core_x, 32'h0);
        check_eq({tag, "_core_funct5"}, core_funct5, 5'h0);
        check_eq({tag, "_busy"}, busy, 1'b0);
        check_eq({tag, "_err"}, err, 1'b0);
    endtask

    initial begin
        int e0;
        int seq;
        logic [31:0]      s_res;
        logic [TAG_W-1:0] s_tag;
        logic             s_to;

        rst = 1'b1; flush = 1'b0; req_valid = 1'b0; resp_ready = 1'b0;
        req_x = '0; req_y = '0; req_z = '0; req_funct5 = '0; req_rm = '0; req_tag = '0;
        core_valid = 1'b0; core_res = '0;

        // Power-on reset, released between edges
        repeat (2) @(posedge clk);
        #2;
        check_outputs_zero("rst");
        #2;
        rst = 1'b0;
        tick();
        check_eq("ready_after_rst", req_ready, 1'b1);

        // Single op, core latency 5
        resp_ready = 1'b1;
        lat_cfg    = 5;
        e0         = en_count;
        send(5'd7, 32'h3f800000, 32'h40000000, 32'h0, FDIV, 10);
        wait_idle("single_idle", 40);
        check_eq("single_en_lat", en_cyc - acc_cyc, 2);
        check_eq("single_resp_lat", rv_cyc - acc_cyc, 8);
        check_eq("single_en_count", en_count - e0, 1);

        // Back-to-back fill beyond DEPTH
        e0            = en_count;
        saw_not_ready = 1'b0;
        for (int i = 0; i < 6; i++) send_rand(TAG_W'(i));
        wait_idle("b2b_idle", 200);
        check_eq("b2b_en_count", en_count - e0, 6);
        check_eq("b2b_saw_full", saw_not_ready, 1'b1);

        // Response backpressure
        resp_ready = 1'b0;
        lat_cfg    = 3;
        send_rand(5'd9);
        wait_resp("bp_resp", 20);
        s_res = resp_res; s_tag = resp_tag; s_to = resp_timeout;
        e0    = en_count;
        for (int i = 10; i < 14; i++) send_rand(TAG_W'(i));
        check_eq("bp_full_ready", req_ready, 1'b0);
        for (int i = 0; i < 10; i++) begin
            check_eq("bp_valid", resp_valid, 1'b1);
            check_eq("bp_res", resp_res, s_res);
            check_eq("bp_tag", resp_tag, s_tag);
            check_eq("bp_to", resp_timeout, s_to);
            tick();
        end
        check_eq("bp_no_en", en_count - e0, 0);
        resp_ready = 1'b1;
        wait_idle("bp_idle", 200);

        // Watchdog with a hung core, then a stray strobe in IDLE
        hang_cfg = 1'b1;
        send_rand(5'd3);
        wait_resp("wd_resp", 100);
        tick();
        check_eq("wd_lat", rv_cyc - en_cyc, TIMEOUT);
        hang_cfg = 1'b0;
        wait_idle("wd_idle", 20);
        check_eq("wd_err_before", err, 1'b0);
        stray_req = 1'b1;
        tick();
        tick();
        check_eq("wd_err_stray", err, 1'b1);

        // Asynchronous reset in the middle of WAIT
        lat_cfg = 20;
        e0      = en_count;
        send_rand(5'd21);
        for (int i = 0; i < 10 && en_count == e0; i++) tick();
        tick();
        tick();
        check_eq("arst_in_wait", busy, 1'b1);
        #1;
        rst = 1'b1;
        pend_q.delete(); infl_q.delete(); st_pend = 0; core_valid = 1'b0; ready_ok = 1'b0;
        #1;
        check_outputs_zero("arst");
        #1;
        rst = 1'b0;
        tick();
        check_eq("arst_ready_after", req_ready, 1'b1);

        // Flush while WAIT with three queued
        lat_cfg = 8;
        for (int i = 0; i < 4; i++) send_rand(TAG_W'(16 + i));
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check_eq("flush_drain_busy", busy, 1'b1);
        wait_idle("flush_idle", 40);
        check_eq("flush_err", err, 1'b0);
        lat_cfg = 4;
        send_rand(5'd30);
        wait_idle("flush_next_idle", 40);

        // Randomized traffic with backpressure, flushes and occasional hangs
        rand_lat = 1'b1;
        seq      = 0;
        for (int i = 0; i < 400; i++) begin
            if (!req_valid || last_acc) begin
                req_valid  = ($urandom_range(0, 2) != 0);
                req_x      = $urandom;
                req_y      = $urandom;
                req_z      = $urandom;
                req_funct5 = ($urandom_range(0, 1) != 0) ? FDIV : FSQRT;
                req_rm     = 3'($urandom_range(0, 7));
                req_tag    = TAG_W'(seq);
                seq++;
            end
            resp_ready = ($urandom_range(0, 3) != 0);
            flush      = ($urandom_range(0, 39) == 0);
            tick();
        end
        req_valid  = 1'b0;
        flush      = 1'b0;
        resp_ready = 1'b1;
        rand_lat   = 1'b0;
        wait_idle("rand_idle", 800);
        check_eq("rand_err", err, 1'b0);
        check_eq("rand_sb_empty", pend_q.size() + infl_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
